// File: rtl/vga_bus_interface_pkg.sv
// Shared register map, control bit positions and types for the mini-VGA bus front end.
package vga_bus_interface_pkg;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_CLEAR   = 0;
  localparam int CTRL_AUTOINC = 1;
  localparam int CTRL_ACK     = 2;

  localparam int FB_BYTES_DEFAULT = 38400;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] dat;
  } bus_word_t;

endpackage

// File: rtl/vga_bus_interface_bus_sync.sv
// N-flop synchroniser with optional rising-edge pulse on bit 0.
// Latency STAGES clk; the pulse is combinational from the last stage.
module bus_sync #(
  parameter int WIDTH   = 1,
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o
);

  // An edge-detecting chain resets to ones so that a level already high when
  // reset is released is never mistaken for a fresh rising edge.
  localparam logic [WIDTH-1:0] RST_VAL = EDGE_EN ? '1 : '0;

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          prev_q <= 1'b1;
        end else begin
          prev_q <= q_o[0];
        end
      end
      assign rise_o = q_o[0] & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/vga_bus_interface.sv
// Z80 I/O front end: synchronises writes, decodes the 4-register file, drives framebuffer
// byte writes and the clear-screen sequencer.
module vga_bus_interface
  import vga_bus_interface_pkg::*;
#(
  parameter int FB_BYTES    = FB_BYTES_DEFAULT,
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iorq,
  input  logic              write,
  input  logic [1:0]        chipsel,
  input  logic [7:0]        data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              busy,
  output logic              dropped
);

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_BYTES - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam int                HI_W    = ADDR_W - 8;

  logic                         strobe_rise;
  logic                         strobe_lvl;
  logic                         bus_rise;
  logic [$bits(bus_word_t)-1:0] bus_raw;
  bus_word_t                    bus_q;
  logic                         unused_sync;

  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_strobe_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (iorq & write),
    .q_o    (strobe_lvl),
    .rise_o (strobe_rise)
  );

  bus_sync #(.WIDTH($bits(bus_word_t)), .STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_bus_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({chipsel, data}),
    .q_o    (bus_raw),
    .rise_o (bus_rise)
  );

  assign bus_q       = bus_word_t'(bus_raw);
  assign unused_sync = strobe_lvl ^ bus_rise;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              fb_we_q, fb_we_d;
  logic              autoinc_q, autoinc_d;
  logic              dropped_q, dropped_d;
  logic              clearing;

  assign clearing = (state_q == ST_CLEAR);

  function automatic logic [ADDR_W-1:0] fold_addr(input logic [ADDR_W-1:0] v);
    return (v > FB_LAST) ? '0 : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_cnt_d  = clr_cnt_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    autoinc_d  = autoinc_q;
    dropped_d  = dropped_q;

    if (clearing) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = clr_cnt_q;
      fb_wdata_d = '0;
      clr_cnt_d  = clr_cnt_q + ONE;
    end

    if (strobe_rise) begin
      case (bus_q.sel)
        REG_ADDR_LO: ptr_d = fold_addr({ptr_q[ADDR_W-1:8], bus_q.dat});
        REG_ADDR_HI: ptr_d = fold_addr({bus_q.dat[HI_W-1:0], ptr_q[7:0]});
        REG_DATA: begin
          if (clearing) begin
            dropped_d = 1'b1;
          end else begin
            fb_we_d    = 1'b1;
            fb_addr_d  = ptr_q;
            fb_wdata_d = bus_q.dat;
            if (autoinc_q) begin
              ptr_d = (ptr_q == FB_LAST) ? '0 : ptr_q + ONE;
            end
          end
        end
        default: begin
          autoinc_d = bus_q.dat[CTRL_AUTOINC];
          if (bus_q.dat[CTRL_ACK]) begin
            dropped_d = 1'b0;
          end
          if (bus_q.dat[CTRL_CLEAR] && !clearing) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end
        end
      endcase
    end

    // The final clear write wins over any pointer load landing on the same edge.
    if (clearing && (clr_cnt_q == FB_LAST)) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      clr_cnt_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      autoinc_q  <= 1'b1;
      dropped_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      autoinc_q  <= autoinc_d;
      dropped_q  <= dropped_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign busy     = clearing;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_vga_bus_interface.sv
// Bench for vga_bus_interface: randomized Z80 register traffic against a register-level model.
module tb_vga_bus_interface;

  localparam int FB   = 38400;
  localparam int AW   = 16;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iorq = 1'b0;
  logic          write = 1'b0;
  logic [1:0]    chipsel = 2'd0;
  logic [7:0]    data = 8'd0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
  logic          busy;
  logic          dropped;

  vga_bus_interface #(.FB_BYTES(FB), .ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .iorq     (iorq),
    .write    (write),
    .chipsel  (chipsel),
    .data     (data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .busy     (busy),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  bit busy_prev = 1'b0;

  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];

  // Register-level model of the programmer-visible state.
  int m_ptr;
  bit m_autoinc;
  bit m_dropped;
  bit m_busy;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fb_we === 1'b1) obs_q.push_back({fb_addr, fb_wdata});
    if (busy === 1'b1 && !busy_prev) rise_cyc = cyc;
    if (busy !== 1'b1 && busy_prev) fall_cyc = cyc;
    busy_prev = (busy === 1'b1);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_reset();
    m_ptr = 0;
    m_autoinc = 1'b1;
    m_dropped = 1'b0;
    m_busy = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_apply(input logic [1:0] sel, input logic [7:0] dat);
    int v;
    case (sel)
      2'd0: begin
        v = (m_ptr & 32'hFF00) | int'(dat);
        m_ptr = (v >= FB) ? 0 : v;
      end
      2'd1: begin
        v = (int'(dat) << 8) | (m_ptr & 32'hFF);
        m_ptr = (v >= FB) ? 0 : v;
      end
      2'd2: begin
        if (m_busy) begin
          m_dropped = 1'b1;
        end else begin
          exp_q.push_back({16'(m_ptr), dat});
          if (m_autoinc) m_ptr = (m_ptr + 1) % FB;
        end
      end
      default: begin
        m_autoinc = dat[1];
        if (dat[2]) m_dropped = 1'b0;
        if (dat[0] && !m_busy) m_busy = 1'b1;
      end
    endcase
  endfunction

  // One Z80 OUT: strobe high for 'hold' clocks, then low; reports when fb_we first
  // rose (posedges counted from the first one that sees the strobe) and how long it stayed high.
  task automatic bus_op(input logic [1:0] sel, input logic [7:0] dat, input int hold,
                        output int lat, output int width);
    @(negedge clk);
    chipsel = sel;
    data = dat;
    iorq = 1'b1;
    write = 1'b1;
    lat = -1;
    width = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (fb_we === 1'b1) begin
        if (lat < 0) lat = k;
        width++;
      end
      @(negedge clk);
      if (k == hold) begin
        iorq = 1'b0;
        write = 1'b0;
        chipsel = 2'($urandom);
        data = 8'($urandom);
      end
    end
    model_apply(sel, dat);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40000 && busy === 1'b1; k++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b want 0", tag, busy);
    end
    m_busy = 1'b0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
    checks++;
    if (fb_addr !== 16'h0000) begin errors++; $display("FAIL reset_fb_addr got %h want 0000", fb_addr); end
    checks++;
    if (fb_wdata !== 8'h00) begin errors++; $display("FAIL reset_fb_wdata got %h want 00", fb_wdata); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %b want 0", dropped); end
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    obs_q.delete();
  endtask

  task automatic test_basic();
    int lat, w;
    bus_op(2'd0, 8'h10, 2, lat, w);
    bus_op(2'd1, 8'h00, 1, lat, w);
    bus_op(2'd2, 8'hA5, 3, lat, w);
    checks++;
    if (lat !== SYNC + 1) begin errors++; $display("FAIL basic_latency0 got %0d want %0d", lat, SYNC + 1); end
    checks++;
    if (w !== 1) begin errors++; $display("FAIL basic_width0 got %0d want 1", w); end
    bus_op(2'd2, 8'h3C, 1, lat, w);
    checks++;
    if (lat !== SYNC + 1) begin errors++; $display("FAIL basic_latency1 got %0d want %0d", lat, SYNC + 1); end
    checks++;
    if (w !== 1) begin errors++; $display("FAIL basic_width1 got %0d want 1", w); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int lat, w;
    bus_op(2'd0, 8'hFF, 1, lat, w);
    bus_op(2'd1, 8'h95, 2, lat, w);
    bus_op(2'd2, 8'hFF, 1, lat, w);
    bus_op(2'd2, 8'hFF, 4, lat, w);
    bus_op(2'd1, 8'hC0, 1, lat, w);
    bus_op(2'd2, 8'($urandom), 2, lat, w);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int lat, w;
    logic [1:0] sel;
    logic [7:0] dat;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        iorq = 1'($urandom);
        write = ~iorq;
        chipsel = 2'd2;
        data = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        iorq = 1'b0;
        write = 1'b0;
        repeat (6) @(negedge clk);
      end else begin
        sel = 2'($urandom_range(0, 3));
        dat = 8'($urandom);
        if (sel == 2'd3) dat[0] = 1'b0;
        bus_op(sel, dat, $urandom_range(1, 4), lat, w);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (dropped !== m_dropped) begin errors++; $display("FAIL random_dropped got %b want %b", dropped, m_dropped); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_clear_full();
    int lat, w, bad;
    bus_op(2'd0, 8'h33, 1, lat, w);
    obs_q.delete();
    exp_q.delete();
    bus_op(2'd3, 8'h03, 1, lat, w);
    wait_idle("clear");
    checks++;
    if (fall_cyc - rise_cyc !== FB) begin
      errors++; $display("FAIL clear_busy_cycles got %0d want %0d", fall_cyc - rise_cyc, FB);
    end
    checks++;
    if (obs_q.size() != FB) begin errors++; $display("FAIL clear_count got %0d want %0d", obs_q.size(), FB); end
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== {16'(i), 8'h00}) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_sweep got %0d bad entries want 0", bad); end
    checks++;
    if (fb_we !== 1'b0) begin errors++; $display("FAIL clear_we_after got %b want 0", fb_we); end
    obs_q.delete();
    bus_op(2'd2, 8'($urandom), 2, lat, w);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL clear_ptr_zero got %0d writes first %h want %h", obs_q.size(), obs_q.size() ? obs_q[0] : 24'h0, exp_q[0]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_autoinc_off();
    int lat, w;
    bus_op(2'd3, 8'h00, 1, lat, w);
    bus_op(2'd0, 8'h05, 2, lat, w);
    bus_op(2'd1, 8'h00, 1, lat, w);
    bus_op(2'd2, 8'h11, 3, lat, w);
    bus_op(2'd2, 8'h22, 1, lat, w);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL autoinc_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL autoinc_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_drop();
    int lat, w, bad;
    bus_op(2'd3, 8'h01, 1, lat, w);
    bus_op(2'd2, 8'h55, 2, lat, w);
    checks++;
    if (dropped !== m_dropped) begin errors++; $display("FAIL drop_set got %b want %b", dropped, m_dropped); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", busy); end
    bus_op(2'd3, 8'h01, 1, lat, w);
    bus_op(2'd3, 8'h06, 1, lat, w);
    checks++;
    if (dropped !== m_dropped) begin errors++; $display("FAIL drop_ack got %b want %b", dropped, m_dropped); end
    wait_idle("drop");
    checks++;
    if (fall_cyc - rise_cyc !== FB) begin
      errors++; $display("FAIL drop_busy_cycles got %0d want %0d", fall_cyc - rise_cyc, FB);
    end
    bad = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== {16'(i), 8'h00}) bad++;
    checks++;
    if (obs_q.size() != FB || bad != 0) begin
      errors++; $display("FAIL drop_sweep got %0d writes %0d bad want %0d writes 0 bad", obs_q.size(), bad, FB);
    end
    obs_q.delete();
    exp_q.delete();
    bus_op(2'd2, 8'($urandom), 1, lat, w);
    bus_op(2'd2, 8'($urandom), 2, lat, w);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drop_after_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_after_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int lat, w;
    bus_op(2'd3, 8'h01, 1, lat, w);
    bus_op(2'd2, 8'h99, 1, lat, w);
    repeat (50) @(negedge clk);
    iorq = 1'b1;
    write = 1'b1;
    chipsel = 2'd2;
    data = 8'h77;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fb_we !== 1'b0) begin errors++; $display("FAIL rstmid_fb_we got %b want 0", fb_we); end
    checks++;
    if (fb_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_fb_addr got %h want 0000", fb_addr); end
    checks++;
    if (fb_wdata !== 8'h00) begin errors++; $display("FAIL rstmid_fb_wdata got %h want 00", fb_wdata); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL rstmid_dropped got %b want 0", dropped); end
    obs_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    iorq = 1'b0;
    write = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_stray got %0d writes want 0", obs_q.size()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
    model_reset();
    obs_q.delete();
    bus_op(2'd2, 8'h5A, 2, lat, w);
    bus_op(2'd2, 8'hA5, 1, lat, w);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_after_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_after_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_clear_full();
    test_autoinc_off();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
